// File: rtl/rob_commit_if.sv
// Bundle of the reorder buffer's decoder, operand-query, writeback and
// retirement signals. The slave side is the reorder buffer itself; the
// master side is whatever drives issue/writeback and consumes commits.
interface rob_commit_if #(
    parameter int ROB_W = 4
);
    // Issue from the decoder
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             issue_is_branch;
    logic             issue_is_store;
    logic             issue_pred_taken;
    logic [31:0]      issue_alt_pc;
    logic             issue_done;
    logic [31:0]      issue_value;
    logic             rob_full;
    logic [ROB_W-1:0] rob_tail_id;

    // Operand lookup by producer id
    logic [ROB_W-1:0] query_id1;
    logic [ROB_W-1:0] query_id2;
    logic             query_ready1;
    logic             query_ready2;
    logic [31:0]      query_value1;
    logic [31:0]      query_value2;

    // Writeback buses
    logic             rs_ready;
    logic [ROB_W-1:0] rs_rob_id;
    logic [31:0]      rs_value;
    logic             lsb_ready;
    logic [ROB_W-1:0] lsb_rob_id;
    logic [31:0]      lsb_value;

    // Retirement and flush
    logic             commit_valid;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_value;
    logic [ROB_W-1:0] commit_rob_id;
    logic             commit_store;
    logic             rob_clear;
    logic [31:0]      redirect_pc;

    modport slave (
        input  issue_valid, issue_rd, issue_is_branch, issue_is_store,
               issue_pred_taken, issue_alt_pc, issue_done, issue_value,
               query_id1, query_id2,
               rs_ready, rs_rob_id, rs_value,
               lsb_ready, lsb_rob_id, lsb_value,
        output rob_full, rob_tail_id,
               query_ready1, query_ready2, query_value1, query_value2,
               commit_valid, commit_rd, commit_value, commit_rob_id,
               commit_store, rob_clear, redirect_pc
    );

    modport master (
        output issue_valid, issue_rd, issue_is_branch, issue_is_store,
               issue_pred_taken, issue_alt_pc, issue_done, issue_value,
               query_id1, query_id2,
               rs_ready, rs_rob_id, rs_value,
               lsb_ready, lsb_rob_id, lsb_value,
        input  rob_full, rob_tail_id,
               query_ready1, query_ready2, query_value1, query_value2,
               commit_valid, commit_rd, commit_value, commit_rob_id,
               commit_store, rob_clear, redirect_pc
    );
endinterface

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates one entry per issued instruction, captures
// results from the RS/ALU and LSB writeback buses, retires strictly in
// program order one entry per cycle, and flushes on a mispredicted branch.
module rob_commit_unit #(
    parameter int ROB_W = 4
) (
    input logic         clk,
    input logic         rst,
    input logic         rdy,
    rob_commit_if.slave bus
);
    localparam int DEPTH = 1 << ROB_W;
    localparam logic [ROB_W:0] CNT_FULL = (ROB_W + 1)'(DEPTH);
    localparam logic [ROB_W:0] CNT_ALMOST = (ROB_W + 1)'(DEPTH - 1);

    // Control state
    logic [ROB_W-1:0] head;
    logic [ROB_W-1:0] tail;
    logic [ROB_W:0]   count;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;

    // Entry payload (not reset; only meaningful while busy)
    logic [4:0]  rd_q        [DEPTH];
    logic [31:0] value_q     [DEPTH];
    logic        is_branch_q [DEPTH];
    logic        is_store_q  [DEPTH];
    logic        pred_q      [DEPTH];
    logic [31:0] alt_pc_q    [DEPTH];

    // Registered outputs
    logic             commit_valid_r;
    logic [4:0]       commit_rd_r;
    logic [31:0]      commit_value_r;
    logic [ROB_W-1:0] commit_rob_id_r;
    logic             commit_store_r;
    logic             rob_clear_r;
    logic [31:0]      redirect_pc_r;

    // Local copies of the writeback buses
    logic             rs_ready;
    logic [ROB_W-1:0] rs_rob_id;
    logic [31:0]      rs_value;
    logic             lsb_ready;
    logic [ROB_W-1:0] lsb_rob_id;
    logic [31:0]      lsb_value;

    assign rs_ready   = bus.rs_ready;
    assign rs_rob_id  = bus.rs_rob_id;
    assign rs_value   = bus.rs_value;
    assign lsb_ready  = bus.lsb_ready;
    assign lsb_rob_id = bus.lsb_rob_id;
    assign lsb_value  = bus.lsb_value;

    logic count_full;
    logic commit_fire;
    logic mispredict;
    logic issue_accept;
    logic rs_wb;
    logic lsb_wb;

    // Datapath decisions for this cycle; commit uses registered done only,
    // so a writeback to the head retires one edge later at the earliest.
    always_comb begin
        count_full   = (count == CNT_FULL);
        commit_fire  = (count != '0) && busy[head] && done[head] && !rob_clear_r;
        mispredict   = commit_fire && is_branch_q[head] &&
                       (value_q[head][0] != pred_q[head]);
        issue_accept = bus.issue_valid && !rob_clear_r && !count_full;
        rs_wb        = rs_ready && !rob_clear_r && busy[rs_rob_id];
        lsb_wb       = lsb_ready && !rob_clear_r && busy[lsb_rob_id];
    end

    // Operand lookup: stored result first, then same-cycle RS bypass, then LSB.
    function automatic logic [32:0] lookup(input logic [ROB_W-1:0] id);
        logic [32:0] r;
        r = '0;
        if (busy[id]) begin
            if (done[id])
                r = {1'b1, value_q[id]};
            else if (rs_ready && rs_rob_id == id)
                r = {1'b1, rs_value};
            else if (lsb_ready && lsb_rob_id == id)
                r = {1'b1, lsb_value};
        end
        return r;
    endfunction

    logic [32:0] q1;
    logic [32:0] q2;

    // Both query ports resolve through the same lookup.
    always_comb begin
        q1 = lookup(bus.query_id1);
        q2 = lookup(bus.query_id2);
    end

    assign bus.query_ready1 = q1[32];
    assign bus.query_value1 = q1[31:0];
    assign bus.query_ready2 = q2[32];
    assign bus.query_value2 = q2[31:0];

    assign bus.rob_full = count_full ||
                          (count == CNT_ALMOST && bus.issue_valid && !commit_fire);
    assign bus.rob_tail_id   = tail;
    assign bus.commit_valid  = commit_valid_r;
    assign bus.commit_rd     = commit_rd_r;
    assign bus.commit_value  = commit_value_r;
    assign bus.commit_rob_id = commit_rob_id_r;
    assign bus.commit_store  = commit_store_r;
    assign bus.rob_clear     = rob_clear_r;
    assign bus.redirect_pc   = redirect_pc_r;

    // Entry payload capture: issue fills the tail, writebacks update results
    // (RS written last so it wins on an illegal id collision).
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (issue_accept) begin
                rd_q[tail]        <= bus.issue_rd;
                value_q[tail]     <= bus.issue_value;
                is_branch_q[tail] <= bus.issue_is_branch;
                is_store_q[tail]  <= bus.issue_is_store;
                pred_q[tail]      <= bus.issue_pred_taken;
                alt_pc_q[tail]    <= bus.issue_alt_pc;
            end
            if (lsb_wb)
                value_q[lsb_rob_id] <= lsb_value;
            if (rs_wb)
                value_q[rs_rob_id] <= rs_value;
        end
    end

    // Pointers, occupancy, entry status and retirement/flush outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            busy            <= '0;
            done            <= '0;
            commit_valid_r  <= 1'b0;
            commit_rd_r     <= '0;
            commit_value_r  <= '0;
            commit_rob_id_r <= '0;
            commit_store_r  <= 1'b0;
            rob_clear_r     <= 1'b0;
            redirect_pc_r   <= '0;
        end else if (rdy) begin
            if (issue_accept) begin
                busy[tail] <= 1'b1;
                done[tail] <= bus.issue_done;
                tail       <= tail + 1'b1;
            end
            if (lsb_wb)
                done[lsb_rob_id] <= 1'b1;
            if (rs_wb)
                done[rs_rob_id] <= 1'b1;

            commit_valid_r <= commit_fire;
            commit_store_r <= commit_fire && is_store_q[head];
            if (commit_fire) begin
                busy[head]      <= 1'b0;
                head            <= head + 1'b1;
                commit_rob_id_r <= head;
                commit_rd_r     <= (is_branch_q[head] || is_store_q[head]) ? 5'd0 : rd_q[head];
                commit_value_r  <= value_q[head];
            end

            count <= count + (ROB_W + 1)'(issue_accept) - (ROB_W + 1)'(commit_fire);

            // A mispredicted branch at the head empties the whole buffer.
            rob_clear_r <= mispredict;
            if (mispredict) begin
                redirect_pc_r <= alt_pc_q[head];
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                busy          <= '0;
            end
        end else begin
            commit_valid_r <= 1'b0;
            commit_store_r <= 1'b0;
            rob_clear_r    <= 1'b0;
        end
    end
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
Reorder buffer that sits directly downstream of the reservation station and load/store buffer. It allocates one entry per issued instruction and captures results from the RS/ALU and LSB writeback buses. It retires entries strictly in program order, one per cycle. On a mispredicted branch reaching the head, it flushes the machine by pulsing rob_clear and supplying the corrected PC.

Parameters:
ROB_W, 4, entry-index width; depth = 2**ROB_W entries (16)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low = hold all state
issue_valid  in  1  decoder issues one instruction this cycle
issue_rd  in  5  destination register (0 = no write)
issue_is_branch  in  1  entry is a conditional branch
issue_is_store  in  1  entry is a store
issue_pred_taken  in  1  fetch-time prediction
issue_alt_pc  in  32  PC to fetch if the prediction is wrong
issue_done  in  1  result already known at issue (lui/auipc/jal)
issue_value  in  32  result when issue_done=1
rob_full  out  1  decoder must not issue
rob_tail_id  out  ROB_W  id the next issued entry receives
query_id1, query_id2  in  ROB_W  operand producer ids from decoder
query_ready1, query_ready2  out  1  producer result available
query_value1, query_value2  out  32  producer result
rs_ready  in  1  RS/ALU writeback valid
rs_rob_id  in  ROB_W  RS/ALU writeback id
rs_value  in  32  RS/ALU writeback value; bit0 = actual taken for branches
lsb_ready  in  1  LSB writeback valid (load data or store address done)
lsb_rob_id  in  ROB_W  LSB writeback id
lsb_value  in  32  LSB writeback value
commit_valid  out  1  one-cycle pulse: head retired
commit_rd  out  5  register-file write address (0 for branch/store)
commit_value  out  32  register-file write data
commit_rob_id  out  ROB_W  id retired; the register file clears its tag if it matches
commit_store  out  1  one-cycle pulse: retired entry was a store; the LSB may perform it
rob_clear  out  1  one-cycle flush pulse
redirect_pc  out  32  valid while rob_clear=1

Behaviour:
- Storage: circular buffer with head, tail (ROB_W bits, wrap naturally) and count (ROB_W+1 bits). Per entry: busy, done, rd, value, is_branch, is_store, pred_taken, alt_pc.
- Reset (rst=1 at posedge): head=tail=count=0, all busy=0. All outputs 0 (rob_tail_id=0, query_ready*=0).
- rdy=0: no state change. commit_valid, commit_store and rob_clear are registered 0 at that edge.
- Issue: when issue_valid && !rob_clear, write entry[tail] with busy=1, done=issue_done, value=issue_value (plus other fields), then tail+1. No accept when count==DEPTH.
- rob_full (combinational): count==DEPTH, or (count==DEPTH-1 && issue_valid && !commit_fire).
- Writeback: rs_ready sets done=1 and value=rs_value on busy entry rs_rob_id; lsb_ready does the same for lsb_rob_id. Writeback to a non-busy id is ignored. Equal ids on both buses is illegal; the RS value wins.
- commit_fire (combinational) = count!=0 && busy[head] && done[head] && !rob_clear. It uses registered done only, so a writeback to the head commits at the following edge at the earliest.
- On commit_fire: head+1, busy[head]=0. Register commit_valid=1, commit_rob_id=head, commit_rd=(branch|store)?0:rd, commit_value=value, commit_store=is_store. Otherwise commit_valid=commit_store=0.
- Mispredict: commit_fire on a branch with value[0]!=pred_taken. That edge also registers rob_clear=1 and redirect_pc=alt_pc, sets head=tail=count=0 and clears all busy. The branch's own commit_valid still pulses with rd=0. rob_clear falls next edge unless a new mispredict occurs, which is impossible because the buffer is empty.
- While rob_clear=1: issue and both writebacks ignored.
- count update: count + issue_accept - commit_fire. Simultaneous issue and commit at count==DEPTH is impossible because rob_full blocks it.
- Query (combinational): ready = busy[id] && (done[id] || rs_ready&&rs_rob_id==id || lsb_ready&&lsb_rob_id==id). value follows the same priority: stored value, then RS, then LSB. Not busy → ready=0, value=0.

Test Plan:
- Reset then issue rd=5 at id0, rs writeback id0 value 0x1234 → commit_valid=1, commit_rd=5, commit_value=0x1234, commit_rob_id=0 two edges after writeback, count returns 0.
- Issue ids 0,1,2; writebacks arrive 2,0,1 → commits occur in order 0,1,2 on consecutive cycles.
- Issue 16 entries with no writebacks → rob_full=1 after 16th; issue_valid at 17th ignored; tail wraps to 0; one commit drops rob_full.
- Branch id3 pred_taken=1, alt_pc=0x100, rs_value=0 → at its commit rob_clear=1 for one cycle, redirect_pc=0x100, younger entries discarded, rob_tail_id=0.
- Query id1 in the same cycle as rs writeback id1=0xABCD → query_ready1=1, query_value1=0xABCD; the next cycle the value comes from storage.
- rdy low for 3 cycles with head done → no commit, state held; commit fires on the first edge after rdy returns.
